// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter between pipeline write-back and MDU result FIFO; optional starvation guard enabled by WB_ARB_STARVE_EN
module wb_port_arbiter #(
    parameter int WORD     = 64,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_wen,
    input  logic [4:0]      pipe_waddr,
    input  logic [WORD-1:0] pipe_wdata,
    input  logic            mdu_valid,
    input  logic [4:0]      mdu_waddr,
    input  logic [WORD-1:0] mdu_wdata,
    output logic            mdu_ready,
    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [WORD-1:0] rf_wdata,
    output logic            pipe_stall
);

    localparam int         PTR_W = $clog2(DEPTH);
    localparam logic [4:0] XZR   = 5'd31;

    // FIFO storage and pointers; the extra pointer bit separates full from empty
    logic [4:0]      addr_mem_q [DEPTH];
    logic [4:0]      addr_mem_d [DEPTH];
    logic [WORD-1:0] data_mem_q [DEPTH];
    logic [WORD-1:0] data_mem_d [DEPTH];
    logic [PTR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]  rd_ptr_q, rd_ptr_d;

    logic            rf_wen_q, rf_wen_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [WORD-1:0] rf_wdata_q, rf_wdata_d;

    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            pipe_req;
    logic            force_grant;
    logic            grant_fifo;
    logic            grant_pipe;
    logic [4:0]      head_addr;
    logic [WORD-1:0] head_data;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head_addr  = addr_mem_q[rd_ptr_q[PTR_W-1:0]];
    assign head_data  = data_mem_q[rd_ptr_q[PTR_W-1:0]];

    // Ready reflects start-of-cycle occupancy only, so a same-cycle dequeue never frees a full FIFO
    assign mdu_ready = !fifo_full;
    // Writes to x31 are dropped: the MDU handshake still completes, the pipeline request vanishes
    assign push      = mdu_valid && !fifo_full && (mdu_waddr != XZR);
    assign pipe_req  = pipe_wen && (pipe_waddr != XZR);

`ifdef WB_ARB_STARVE_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] THR     = CNT_W'((MAX_WAIT > 1) ? (MAX_WAIT - 1) : 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    assign force_grant = (state_q == ST_FORCE);
    assign pipe_stall  = (state_q == ST_FORCE);
    assign cnt_inc     = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;

    // Starvation guard: count cycles the FIFO head is passed over, force one grant at the threshold
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !grant_fifo) begin
                    wait_cnt_d = cnt_inc;
                    state_d    = (cnt_inc >= THR) ? ST_FORCE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (grant_fifo) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = cnt_inc;
                    if (cnt_inc >= THR) begin
                        state_d = ST_FORCE;
                    end
                end
            end
            ST_FORCE: begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Guard state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign force_grant = 1'b0;
    assign pipe_stall  = 1'b0;
`endif

    // Grant: forced head first, then pipeline, then FIFO head in pipeline idle cycles
    assign grant_fifo = !fifo_empty && (force_grant || !pipe_req);
    assign grant_pipe = pipe_req && !force_grant;

    // FIFO next state
    always_comb begin
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        if (push) begin
            addr_mem_d[wr_ptr_q[PTR_W-1:0]] = mdu_waddr;
            data_mem_d[wr_ptr_q[PTR_W-1:0]] = mdu_wdata;
        end
        wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, grant_fifo};
    end

    // Register-file write outputs; address/data hold their last value when no write is granted
    always_comb begin
        rf_wen_d   = grant_fifo || grant_pipe;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_fifo) begin
            rf_waddr_d = head_addr;
            rf_wdata_d = head_data;
        end else if (grant_pipe) begin
            rf_waddr_d = pipe_waddr;
            rf_wdata_d = pipe_wdata;
        end
    end

    // FIFO payload storage needs no reset; emptiness comes from the pointers
    always_ff @(posedge clk) begin
        addr_mem_q <= addr_mem_d;
        data_mem_q <= data_mem_d;
    end

    // Pointers and registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for wb_port_arbiter against a queue-based reference model
module tb_wb_port_arbiter;

    localparam int WORD     = 64;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;
`ifdef WB_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif
    localparam int THR = (MAX_WAIT > 1) ? (MAX_WAIT - 1) : 1;

    logic            clk;
    logic            rst;
    logic            pipe_wen;
    logic [4:0]      pipe_waddr;
    logic [WORD-1:0] pipe_wdata;
    logic            mdu_valid;
    logic [4:0]      mdu_waddr;
    logic [WORD-1:0] mdu_wdata;
    logic            mdu_ready;
    logic            rf_wen;
    logic [4:0]      rf_waddr;
    logic [WORD-1:0] rf_wdata;
    logic            pipe_stall;

    wb_port_arbiter #(
        .WORD     (WORD),
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_wen   (pipe_wen),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .mdu_valid  (mdu_valid),
        .mdu_waddr  (mdu_waddr),
        .mdu_wdata  (mdu_wdata),
        .mdu_ready  (mdu_ready),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .pipe_stall (pipe_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      addr;
        logic [WORD-1:0] data;
        int              cyc;
    } wr_t;

    typedef struct {
        logic [4:0]      addr;
        logic [WORD-1:0] data;
    } ent_t;

    typedef struct {
        bit              v;
        logic [4:0]      addr;
        logic [WORD-1:0] data;
    } req_t;

    wr_t  exp_q[$];
    ent_t model_fifo[$];
    req_t pipe_q[$];
    req_t mdu_q[$];
    int   head_wait = 0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   stall_cnt = 0;
    int   stall_cyc = 0;
    int   enq_cyc = 0;
    bit   saw_not_ready = 0;
    wr_t  mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every register-file write must match the oldest expected write, in its cycle
    always @(negedge clk) begin
        if (rf_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got x%0d=%0h expected no write (cycle %0d)", rf_waddr, rf_wdata, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("wr_addr", 64'(rf_waddr), 64'(mon_e.addr));
                check("wr_data", rf_wdata, mon_e.data);
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_write: got rf_wen=%b expected x%0d=%0h (cycle %0d)", rf_wen, mon_e.addr, mon_e.data, cyc);
        end
    end

    // One clock of stimulus plus the reference model step for that clock
    task automatic run_cycle(input bit do_rst);
        req_t p;
        req_t m;
        bit   exp_stall;
        bit   exp_ready;
        bit   preq;
        ent_t h;
        p = '{v: 1'b0, addr: 5'd0, data: '0};
        m = '{v: 1'b0, addr: 5'd0, data: '0};
        if (pipe_q.size() > 0) p = pipe_q[0];
        if (mdu_q.size() > 0)  m = mdu_q[0];
        rst        = do_rst;
        pipe_wen   = p.v;
        pipe_waddr = p.addr;
        pipe_wdata = p.data;
        mdu_valid  = m.v;
        mdu_waddr  = m.addr;
        mdu_wdata  = m.data;
        @(negedge clk);
        exp_stall = STARVE && (model_fifo.size() > 0) && (head_wait >= THR);
        exp_ready = (model_fifo.size() < DEPTH);
        check("pipe_stall", 64'(pipe_stall), 64'(exp_stall));
        check("mdu_ready", 64'(mdu_ready), 64'(exp_ready));
        if (pipe_stall === 1'b1) begin
            stall_cnt++;
            stall_cyc = cyc;
        end
        if (mdu_ready === 1'b0) saw_not_ready = 1'b1;
        if (do_rst) begin
            model_fifo.delete();
            head_wait = 0;
        end else begin
            preq = p.v && (p.addr != 5'd31);
            if (exp_stall || (!preq && model_fifo.size() > 0)) begin
                h = model_fifo.pop_front();
                exp_q.push_back(wr_t'{addr: h.addr, data: h.data, cyc: cyc + 1});
                head_wait = 0;
            end else if (preq) begin
                exp_q.push_back(wr_t'{addr: p.addr, data: p.data, cyc: cyc + 1});
                if (model_fifo.size() > 0) head_wait++;
            end
            if (m.v && exp_ready) begin
                if (m.addr != 5'd31) model_fifo.push_back(ent_t'{addr: m.addr, data: m.data});
                enq_cyc = cyc;
            end
            if (pipe_q.size() > 0 && !exp_stall) void'(pipe_q.pop_front());
            if (mdu_q.size() > 0 && (!m.v || exp_ready)) void'(mdu_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_empty(input int max_cyc);
        int n;
        n = 0;
        while ((pipe_q.size() > 0 || mdu_q.size() > 0) && n < max_cyc) begin
            run_cycle(1'b0);
            n++;
        end
        check("stim_timeout", 64'(n < max_cyc), 64'd1);
        pipe_q.delete();
        mdu_q.delete();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((model_fifo.size() > 0 || exp_q.size() > 0) && n < 100) begin
            run_cycle(1'b0);
            n++;
        end
        run_cycle(1'b0);
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic req_t mk(input bit v, input int a, input logic [WORD-1:0] d);
        req_t r;
        r.v    = v;
        r.addr = 5'(a);
        r.data = d;
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pipe_wen = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
        mdu_valid = 1'b0; mdu_waddr = '0; mdu_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rf_wen", 64'(rf_wen), 64'd0);
        check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
        check("rst_rf_wdata", rf_wdata, 64'd0);
        check("rst_pipe_stall", 64'(pipe_stall), 64'd0);
        check("rst_mdu_ready", 64'(mdu_ready), 64'd1);

        // pipeline only, then a write to x31
        pipe_q.push_back(mk(1, 5, 100));
        run_cycle(1'b0);
        check("pipe_rf_wen", 64'(rf_wen), 64'd1);
        check("pipe_rf_waddr", 64'(rf_waddr), 64'd5);
        check("pipe_rf_wdata", rf_wdata, 64'd100);
        pipe_q.push_back(mk(1, 31, 100));
        run_cycle(1'b0);
        check("xzr_rf_wen", 64'(rf_wen), 64'd0);
        drain();

        // idle drain of a single MDU result
        mdu_q.push_back(mk(1, 7, 90));
        run_cycle(1'b0);
        run_cycle(1'b0);
        check("drain_rf_wen", 64'(rf_wen), 64'd1);
        check("drain_rf_waddr", 64'(rf_waddr), 64'd7);
        check("drain_rf_wdata", rf_wdata, 64'd90);
        drain();

        // conflict: continuous pipeline writes with one MDU result
        for (int i = 0; i < 12; i++) pipe_q.push_back(mk(1, 1, 64'(200 + i)));
        mdu_q.push_back(mk(1, 9, 80));
        stall_cnt = 0;
        run_until_empty(200);
        drain();
        check("conflict_stalls", 64'(stall_cnt), STARVE ? 64'd1 : 64'd0);
        check("conflict_stall_delay", 64'((stall_cnt > 0) ? (stall_cyc - enq_cyc) : 0),
              STARVE ? 64'(MAX_WAIT) : 64'd0);

        // back-pressure: three MDU results against continuous pipeline writes
        for (int i = 0; i < 16; i++) pipe_q.push_back(mk(1, 2, 64'(300 + i)));
        mdu_q.push_back(mk(1, 10, 1));
        mdu_q.push_back(mk(1, 11, 2));
        mdu_q.push_back(mk(1, 12, 3));
        saw_not_ready = 1'b0;
        run_until_empty(200);
        drain();
        check("backpressure_seen", 64'(saw_not_ready), 64'd1);

        // reset with two queued results
        for (int i = 0; i < 6; i++) pipe_q.push_back(mk(1, 3, 64'(400 + i)));
        mdu_q.push_back(mk(1, 13, 4));
        mdu_q.push_back(mk(1, 14, 5));
        repeat (3) run_cycle(1'b0);
        pipe_q.delete();
        mdu_q.delete();
        run_cycle(1'b1);
        run_cycle(1'b1);
        check("midrst_mdu_ready", 64'(mdu_ready), 64'd1);
        check("midrst_pipe_stall", 64'(pipe_stall), 64'd0);
        repeat (8) run_cycle(1'b0);
        drain();

        // randomized traffic
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 60; i++) begin
                pipe_q.push_back(mk($urandom_range(0, 9) < (3 + 2 * r),
                                    ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 30),
                                    {$urandom, $urandom}));
            end
            for (int i = 0; i < 40; i++) begin
                mdu_q.push_back(mk($urandom_range(0, 2) == 0,
                                   ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 30),
                                   {$urandom, $urandom}));
            end
            run_until_empty(2000);
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
